// File: rtl/demux_dispatch_ctrl.sv
// Credit-based round-robin dispatcher driving a 1:4 demux datapath.
// Steers each accepted beat to the next lane (round-robin from rr_ptr) that holds a
// credit, tracks per-lane downstream credits and stalls the source when none remain.
// Optional feature: define DEMUX_LANE_MASK_EN to add the lane_en[3:0] lane mask input.
module demux_dispatch_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        sel,
`ifdef DEMUX_LANE_MASK_EN
  input  logic [3:0]        lane_en,
`endif
  input  logic [3:0]        credit_ret,
  output logic              stall,
  output logic              err
);

  localparam logic [3:0] CredInit = 4'(CREDITS);
  localparam logic [4:0] CredMax  = 5'(CREDITS);

  typedef enum logic [1:0] {StIdle, StRun, StStall} state_e;

  state_e            state_q, state_d;
  logic [3:0]        credit_q [4];
  logic [3:0]        credit_d [4];
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]        out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        sel_q, sel_d;
  logic              err_q, err_d;

  logic [3:0] lane_avail;
  logic [3:0] lane_mask;
  logic [1:0] lane;
  logic       accept;
  logic [3:0] dec;
  logic       credits_zero_next;

`ifdef DEMUX_LANE_MASK_EN
  assign lane_mask = lane_en;
`else
  assign lane_mask = 4'b1111;
`endif

  // Lanes eligible for selection: nonzero credit and not masked off.
  always_comb begin
    lane_avail = '0;
    for (int i = 0; i < 4; i++) begin
      lane_avail[i] = (credit_q[i] != 4'd0) && lane_mask[i];
    end
  end

  assign in_ready = (|lane_avail) && !rst;
  assign accept   = in_valid && in_ready;

  // Round-robin scan starting at rr_ptr; first eligible lane wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    lane  = rr_ptr_q;
    found = 1'b0;
    idx   = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && lane_avail[idx]) begin
        lane  = idx;
        found = 1'b1;
      end
    end
  end

  // Credit bookkeeping: add returns, subtract dispatch, saturate at CREDITS and flag overflow.
  always_comb begin
    logic [4:0] sum;
    dec   = '0;
    err_d = err_q;
    sum   = '0;
    if (accept) dec[lane] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sum = {1'b0, credit_q[i]} + {4'd0, credit_ret[i]} - {4'd0, dec[i]};
      if (sum > CredMax) begin
        credit_d[i] = CredInit;
        err_d       = 1'b1;
      end else begin
        credit_d[i] = sum[3:0];
      end
    end
  end

  assign credits_zero_next = (credit_d[0] == 4'd0) && (credit_d[1] == 4'd0) &&
                             (credit_d[2] == 4'd0) && (credit_d[3] == 4'd0);

  // Datapath next-state: strobe, beat, select and pointer update on accept.
  always_comb begin
    out_valid_d = '0;
    out_data_d  = out_data_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d[lane] = 1'b1;
      out_data_d        = in_data;
      sel_d             = lane;
      rr_ptr_d          = lane + 2'd1;
    end
  end

  // FSM next-state: STALL has priority whenever no credit will remain.
  always_comb begin
    state_d = state_q;
    if (credits_zero_next) begin
      state_d = StStall;
    end else if (accept) begin
      state_d = StRun;
    end else begin
      state_d = StIdle;
    end
  end

  // FSM outputs.
  always_comb begin
    stall = (state_q == StStall);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign err       = err_q;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < 4; i++) credit_q[i] <= CredInit;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sel_q       <= sel_d;
      err_q       <= err_d;
      for (int i = 0; i < 4; i++) credit_q[i] <= credit_d[i];
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl (default build, CREDITS=4, DATA_W=8).
module tb_demux_dispatch_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [1:0] sel;
  logic [3:0] credit_ret;
  logic       stall;
  logic       err;

  int tests;
  int fails;

  demux_dispatch_ctrl #(.DATA_W(8), .CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sel        (sel),
    .credit_ret (credit_ret),
    .stall      (stall),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; credit_ret = 4'b0000;
    step();
    step();
    tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    tests++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    tests++; if (stall !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_stall_err got=%b%b exp=00", stall, err); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_during_rst got=%b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  // 16 beats with continuous valid; lanes rotate 0..3, data lands one cycle later.
  task automatic test_round_robin_exhaust();
    logic [3:0] exp_ov;
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_data = 8'h10 + 8'(k);
      step();
      exp_ov = 4'b0001 << (k % 4);
      tests++;
      if (out_valid !== exp_ov || sel !== 2'(k % 4) || out_data !== 8'h10 + 8'(k)) begin
        fails++;
        $display("FAIL rr_beat%0d got ov=%b sel=%0d data=%h exp ov=%b sel=%0d data=%h",
                 k, out_valid, sel, out_data, exp_ov, k % 4, 8'h10 + 8'(k));
      end
    end
    tests++; if (in_ready !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL exhaust_stall got rdy=%b stall=%b exp rdy=0 stall=1", in_ready, stall); end
    in_data = 8'h99;
    step();
    tests++;
    if (out_valid !== 4'b0000 || out_data !== 8'h1F || sel !== 2'd3 || stall !== 1'b1) begin
      fails++;
      $display("FAIL held_beat got ov=%b data=%h sel=%0d stall=%b exp ov=0000 data=1f sel=3 stall=1",
               out_valid, out_data, sel, stall);
    end
  endtask

  // Return one credit on lane 2 while stalled; the next beat must go to lane 2 only.
  task automatic test_credit_return();
    credit_ret = 4'b0100;
    in_data = 8'h20;
    step();
    credit_ret = 4'b0000;
    tests++; if (stall !== 1'b0 || in_ready !== 1'b1 || out_valid !== 4'b0000) begin fails++; $display("FAIL ret_unstall got stall=%b rdy=%b ov=%b exp 0 1 0000", stall, in_ready, out_valid); end
    step();
    tests++; if (out_valid !== 4'b0100 || sel !== 2'd2 || out_data !== 8'h20) begin fails++; $display("FAIL ret_lane2 got ov=%b sel=%0d data=%h exp ov=0100 sel=2 data=20", out_valid, sel, out_data); end
    tests++; if (stall !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL ret_restall got stall=%b rdy=%b exp 1 0", stall, in_ready); end
    in_valid = 1'b0;
  endtask

  // rr_ptr=3 here; credits on lanes 0 and 2 only. Beat to lane 0 (ptr->1), then lane 1 is
  // skipped so the beat goes to lane 2 (ptr->3), confirmed by the following beat picking lane 3.
  task automatic test_skip_lane();
    credit_ret = 4'b0101;
    step();
    credit_ret = 4'b0000;
    in_valid = 1'b1; in_data = 8'h30;
    step();
    tests++; if (out_valid !== 4'b0001 || sel !== 2'd0) begin fails++; $display("FAIL skip_first got ov=%b sel=%0d exp ov=0001 sel=0", out_valid, sel); end
    in_data = 8'h31;
    step();
    tests++; if (out_valid !== 4'b0100 || sel !== 2'd2 || out_data !== 8'h31) begin fails++; $display("FAIL skip_lane1 got ov=%b sel=%0d data=%h exp ov=0100 sel=2 data=31", out_valid, sel, out_data); end
    in_valid = 1'b0; credit_ret = 4'b1111;
    step();
    credit_ret = 4'b0000;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL skip_no_err got=%b exp=0", err); end
    in_valid = 1'b1; in_data = 8'h32;
    step();
    tests++; if (out_valid !== 4'b1000 || sel !== 2'd3) begin fails++; $display("FAIL skip_ptr3 got ov=%b sel=%0d exp ov=1000 sel=3", out_valid, sel); end
    in_valid = 1'b0;
  endtask

  // Return+dispatch on the same lane is neutral; a return at full credit saturates and sets err.
  task automatic test_err();
    int cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h40; credit_ret = 4'b0001;
    step();
    in_valid = 1'b0; credit_ret = 4'b0000;
    tests++; if (out_valid !== 4'b0001 || err !== 1'b0) begin fails++; $display("FAIL same_lane_ret got ov=%b err=%b exp ov=0001 err=0", out_valid, err); end
    credit_ret = 4'b0001;
    step();
    credit_ret = 4'b0000;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL overflow_err got=%b exp=1", err); end
    step();
    step();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", err); end
    cnt = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 24; n++) begin
      if (in_ready) cnt++;
      step();
    end
    in_valid = 1'b0;
    tests++; if (cnt != 16) begin fails++; $display("FAIL saturated_credits got=%0d beats exp=16", cnt); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky_end got=%b exp=1", err); end
  endtask

  // Reset mid-stream with a beat offered: beat dropped, credits back to 4/4/4/4, lane 0 next.
  task automatic test_reset_mid();
    int cnt;
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h50; step();
    in_data = 8'h51; step();
    rst = 1'b1; in_data = 8'h55;
    step();
    rst = 1'b0;
    tests++; if (out_valid !== 4'b0000 || err !== 1'b0) begin fails++; $display("FAIL rst_mid_drop got ov=%b err=%b exp ov=0000 err=0", out_valid, err); end
    in_data = 8'h56;
    step();
    tests++; if (out_valid !== 4'b0001 || sel !== 2'd0 || out_data !== 8'h56) begin fails++; $display("FAIL rst_mid_resume got ov=%b sel=%0d data=%h exp ov=0001 sel=0 data=56", out_valid, sel, out_data); end
    cnt = 0;
    for (int n = 0; n < 24; n++) begin
      if (in_ready) cnt++;
      step();
    end
    in_valid = 1'b0;
    tests++; if (cnt != 15) begin fails++; $display("FAIL rst_mid_credits got=%0d beats exp=15", cnt); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_robin_exhaust();
    test_credit_return();
    test_skip_lane();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
Credit-based round-robin dispatcher that drives the 1:4 demux datapath. It accepts a single input stream with a valid/ready handshake and steers each beat to one of four output lanes. The lane is the next lane in round-robin order that holds a credit. The block generates the 2-bit select (s1,s0) and the one-hot lane strobes consumed by the demux, tracks downstream buffer space per lane, and stalls the source when no lane can take data.

Parameters:
DATA_W, 8, width of the data beat.
CREDITS, 4, per-lane credit count at reset; legal range 1..15; counters are 4 bits.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  source beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  DATA_W  source beat.
out_valid  output  4  one-hot lane strobe, registered; bit i = beat for lane i.
out_data  output  DATA_W  registered beat, shared by all lanes.
sel  output  2  registered select {s1,s0} of the lane in out_valid; holds its last value when idle.
credit_ret  input  4  per-lane credit return pulses; each asserted bit adds one credit.
stall  output  1  registered; 1 while in STALL state.
err  output  1  sticky overflow flag; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clock edge): credit[0..3]=CREDITS, rr_ptr=0, out_valid=0, out_data=0, sel=0, stall=0, err=0, state=IDLE. rst overrides all other inputs, including credit_ret.
- in_ready is combinational from registers: it is 1 when any credit[i]>0 and rst=0. It never depends on in_valid.
- Accept happens when in_valid&&in_ready at edge t.
  - Lane L is the first lane with credit>0 scanning rr_ptr, rr_ptr+1, ... mod 4.
  - At t+1: out_valid=one-hot(L), out_data=in_data, sel=L.
  - credit[L] decrements and rr_ptr=(L+1) mod 4.
  - Latency is exactly 1 cycle. Throughput is 1 beat/cycle while credits exist.
- When no beat is accepted, out_valid=0 on the next cycle. out_data and sel hold their values.
- Credit update per lane per cycle: credit_next = credit + ret − dec.
  - Simultaneous return and dispatch on the same lane leaves the count unchanged.
  - A return that would exceed CREDITS saturates at CREDITS and sets err=1.
- rr_ptr advances only on accept. Lanes with zero credit are skipped without moving the pointer past the chosen lane.
- FSM states:
  - IDLE: no accept last cycle, credits available.
  - RUN: accept occurred.
  - STALL: all four credits are 0.
- FSM transitions:
  - IDLE→RUN on accept.
  - RUN→RUN on accept.
  - RUN→IDLE when there is no accept and credits are available.
  - any state→STALL when the next-cycle credit total is 0.
  - STALL→IDLE when any credit_ret arrives. The returned credit is usable one cycle later, through in_ready.
- stall=1 exactly while state=STALL.
- Reset mid-operation: a beat presented in the reset cycle is dropped, out_valid=0 on the following cycle, and credits are restored to CREDITS.

Optional Feature:
Macro DEMUX_LANE_MASK_EN.
- When defined: adds input port lane_en[3:0]. A lane with lane_en[i]=0 is treated as having zero credit for selection and in_ready. Its counter still accepts returns.
- When undefined: the port is absent and all lanes are enabled.

Test Plan:
- Reset then continuous in_valid=1 with data 0x10,0x11,...: out_valid sequence is 0001,0010,0100,1000,0001..., sel goes 0,1,2,3,0, and each out_data appears 1 cycle after acceptance.
- CREDITS=4, no credit_ret, 16 beats accepted: after the 16th beat in_ready=0 and stall=1 on the next cycle. The 17th beat is held at the source.
- In the stalled state, pulse credit_ret=0100: stall deasserts, the next beat goes to lane 2 only (out_valid=0100, sel=2), then the block stalls again.
- Credit lane1 is 0, rr_ptr=1, beat offered: beat goes to lane 2. rr_ptr becomes 3.
- Return credit_ret=0001 with credit[0]=CREDITS: credit[0] stays 4 and err=1, and err stays set until rst.
- Assert rst for one cycle mid-stream with in_valid=1: no out_valid the next cycle, credits=4/4/4/4, and dispatch resumes at lane 0.
